// File: rtl/connectnet_pkg.sv
// connectnet_pkg: shared frame constants and FSM states for the connectnet serial link.
package connectnet_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   FIFO_DEPTH = 2;

endpackage

// File: rtl/connectnet_rx_fifo.sv
// connectnet_rx_fifo: 2-entry first-word-fall-through FIFO with simultaneous enq/deq.
module connectnet_rx_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enq_i,
    input  logic [W-1:0] enq_data_i,
    input  logic         deq_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         full_o
);

    logic [W-1:0] d0_q, d1_q, d0_d, d1_d;
    logic         v0_q, v1_q, v0_d, v1_d;
    logic         deq, enq;

    // Entry 0 is always the head; a pop shifts entry 1 down before any push lands.
    always_comb begin
        deq  = deq_i & v0_q;
        enq  = enq_i & (~v1_q | deq);
        v0_d = deq ? v1_q : v0_q;
        d0_d = deq ? d1_q : d0_q;
        v1_d = deq ? 1'b0 : v1_q;
        d1_d = d1_q;
        if (enq && !v0_d) begin
            v0_d = 1'b1;
            d0_d = enq_data_i;
        end else if (enq) begin
            v1_d = 1'b1;
            d1_d = enq_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d0_q <= '0;
            d1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            d0_q <= d0_d;
            d1_q <= d1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign data_o  = d0_q;
    assign valid_o = v0_q;
    assign full_o  = v1_q;

endmodule

// File: rtl/connectnet_rx.sv
// connectnet_rx: serial frame receiver with stop/parity check, error counters and 2-entry output FIFO.
// Define CONNECTNET_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module connectnet_rx
    import connectnet_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     SER_IN,
    output logic [DATA_WIDTH-1:0]    rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     overflow,
    input  logic                     clear_err
);

    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
`ifdef CONNECTNET_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t                   state_q;
    logic [CW-1:0]            bit_cnt_q;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic                     ovf_q;
    logic                     par_ok, good_d, bad_d, push_d, full;

`ifdef CONNECTNET_RX_PARITY_EN
    logic par_q;
    assign par_ok = par_q == ^shift_q;
`else
    assign par_ok = 1'b1;
`endif

    // A full FIFO still takes the word when the head is leaving this same cycle.
    always_comb begin
        good_d = state_q == STOP && SER_IN == STOP_BIT && par_ok;
        bad_d  = state_q == STOP && !good_d;
        push_d = good_d && (!full || (rx_valid && rx_ready));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
`ifdef CONNECTNET_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (SER_IN == START_BIT) begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                end
                DATA: begin
                    shift_q[bit_cnt_q] <= SER_IN;
                    bit_cnt_q          <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CW'(DATA_WIDTH - 1)) state_q <= AFTER_DATA;
                end
`ifdef CONNECTNET_RX_PARITY_EN
                PARITY: begin
                    par_q   <= SER_IN;
                    state_q <= STOP;
                end
`endif
                default: state_q <= IDLE;
            endcase
            if (clear_err) err_cnt_q <= '0;
            else if (bad_d && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
            ovf_q <= clear_err ? 1'b0 : ovf_q | (good_d && !push_d);
        end
    end

    connectnet_rx_fifo #(.W(DATA_WIDTH)) u_fifo (
        .clk_i      (CLK),
        .rst_ni     (RST_N),
        .enq_i      (push_d),
        .enq_data_i (shift_q),
        .deq_i      (rx_ready),
        .data_o     (rx_data),
        .valid_o    (rx_valid),
        .full_o     (full)
    );

    assign err_cnt  = err_cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_connectnet_rx.sv
// tb_connectnet_rx: directed and randomized frames checked against a queue-based receiver model.
module tb_connectnet_rx;

    localparam int DW = 8;
    localparam int EW = 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          SER_IN = 1'b1;
    logic          rx_ready = 1'b0;
    logic          clear_err = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [EW-1:0] err_cnt;
    logic          overflow;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] q[$];
    int          m_err = 0;
    bit          m_ovf = 0;
    int          rdy_mode = 1;
    int          clr_pct = 0;
    bit          par_en;

    connectnet_rx #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(EW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SER_IN    (SER_IN),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err_cnt   (err_cnt),
        .overflow  (overflow),
        .clear_err (clear_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/valid"}, 32'(rx_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk({tag, "/data"}, 32'(rx_data), q[0]);
        chk({tag, "/err_cnt"}, 32'(err_cnt), 32'(m_err));
        chk({tag, "/overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // One serial bit: drive on the falling edge, advance the model at the rising edge, check just after.
    task automatic step(input bit b, input bit stop, input bit good, input logic [DW-1:0] d, input bit clr_force);
        bit rdy, clr;
        @(negedge CLK);
        rdy = rdy_mode == 2 ? bit'($urandom_range(1, 0)) : rdy_mode == 1;
        clr = clr_force || ($urandom_range(99, 0) < clr_pct);
        SER_IN = b;
        rx_ready = rdy;
        clear_err = clr;
        @(posedge CLK);
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (stop && good) begin
            if (q.size() < 2) q.push_back(32'(d));
            else m_ovf = 1;
        end else if (stop && m_err < (1 << EW) - 1) m_err++;
        if (clr) begin
            m_err = 0;
            m_ovf = 0;
        end
        #1 check_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit stopb, input bit flip, input bit clr);
        step(1'b0, 1'b0, 1'b0, d, 1'b0);
        for (int i = 0; i < DW; i++) step(d[i], 1'b0, 1'b0, d, 1'b0);
        if (par_en) step((^d) ^ flip, 1'b0, 1'b0, d, 1'b0);
        step(stopb, 1'b1, stopb && !(par_en && flip), d, clr);
    endtask

    initial begin
`ifdef CONNECTNET_RX_PARITY_EN
        par_en = 1;
`else
        par_en = 0;
`endif
        #1;
        chk("rst/valid", 32'(rx_valid), 0);
        chk("rst/data", 32'(rx_data), 0);
        chk("rst/err_cnt", 32'(err_cnt), 0);
        chk("rst/overflow", 32'(overflow), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(2);

        rdy_mode = 1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(2);

        rdy_mode = 0;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        chk("b2b/overflow", 32'(overflow), 1);
        rdy_mode = 1;
        idle(4);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("badstop/err_cnt", 32'(err_cnt), 1);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(2);

        step(1'b0, 1'b0, 1'b0, 8'h77, 1'b0);
        for (int i = 0; i < 4; i++) step(bit'((8'h77 >> i) & 1), 1'b0, 1'b0, 8'h77, 1'b0);
        RST_N = 1'b0;
        #1;
        q.delete();
        m_err = 0;
        m_ovf = 0;
        chk("midrst/valid", 32'(rx_valid), 0);
        chk("midrst/data", 32'(rx_data), 0);
        chk("midrst/err_cnt", 32'(err_cnt), 0);
        chk("midrst/overflow", 32'(overflow), 0);
        idle(2);
        @(negedge CLK);
        RST_N = 1'b1;
        idle(1);
        send_frame(8'h42, 1'b1, 1'b0, 1'b0);
        idle(2);

        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_frame(8'(i * 37 + 5), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        chk("sat/err_cnt", 32'(err_cnt), 255);
        chk("sat/overflow", 32'(overflow), 1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("clr/err_cnt", 32'(err_cnt), 0);
        chk("clr/overflow", 32'(overflow), 0);
        rdy_mode = 1;
        idle(3);

        if (par_en) begin
            send_frame(8'h07, 1'b1, 1'b0, 1'b0);
            idle(2);
            send_frame(8'h07, 1'b1, 1'b1, 1'b0);
            chk("par/err_cnt", 32'(err_cnt), 1);
            idle(2);
        end

        rdy_mode = 2;
        clr_pct = 3;
        for (int i = 0; i < 300; i++) begin
            send_frame(8'($urandom), $urandom_range(99, 0) < 85, par_en && $urandom_range(9, 0) == 0, 1'b0);
            idle($urandom_range(3, 0));
        end
        clr_pct = 0;
        rdy_mode = 1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
